run_len_detector: RTL
=====================

Name: run_len_detector

Overview:
Parametrised run-length detector on a single-bit serial stream. It flags when the current run of identical bits reaches RUN_LEN, for both runs of 0s and runs of 1s. It adds a sample-valid qualifier, a level/pulse output mode, a visible run-length count and saturating per-polarity event counters. It sits in the same serial-monitor path as the existing fixed 4-bit run detector and replaces it where the run length or event statistics must be configurable.

Parameters:
RUN_LEN, 4, run length that triggers detection; legal range >= 2.
CNT_W, $clog2(RUN_LEN+1), width of run_len output (derived; do not override).
EVT_W, 8, width of each event counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
w_valid  input  1  sample qualifier; w is consumed only on an edge where w_valid=1.
w  input  1  serial data bit.
mode_pulse  input  1  0 = level mode; 1 = pulse mode. Sampled every cycle.
clr_cnt  input  1  synchronous clear of both event counters.
z  output  2  detection: 2'b00 none, 2'b01 zero-run, 2'b10 one-run; 2'b11 never driven.
run_len  output  CNT_W  length of the current run, saturating at RUN_LEN; 0 before the first sample.
cur_bit  output  1  polarity of the current run; 0 in IDLE.
zero_evt_cnt  output  EVT_W  number of 0-runs that reached RUN_LEN; saturating.
one_evt_cnt  output  EVT_W  number of 1-runs that reached RUN_LEN; saturating.

Behaviour:
- Reset: when rst=1 at an edge, the block enters IDLE. z=00, run_len=0, cur_bit=0, and both counters=0. rst overrides all other inputs, including mid-run.
- Outputs: all outputs are registered (Moore). The effect of a sample accepted at edge N is visible in the cycle after edge N. Latency is 1 clock.
- States: IDLE, ZRUN, ORUN.
  - IDLE + accepted w=0 -> ZRUN, run_len=1.
  - IDLE + accepted w=1 -> ORUN, run_len=1.
  - ZRUN + accepted w=0 -> ZRUN, run_len = min(run_len+1, RUN_LEN).
  - ZRUN + accepted w=1 -> ORUN, run_len=1.
  - ORUN is symmetric to ZRUN.
  - With w_valid=0 the state, run_len and cur_bit hold. Gaps do not break a run.
- hit: asserted on an accepted sample that moves run_len from RUN_LEN-1 to RUN_LEN in the same run. hit is never asserted while run_len is already saturated.
- Level mode (mode_pulse=0): z = 01 in ZRUN or 10 in ORUN while run_len==RUN_LEN, else 00. z holds through w_valid gaps and drops on the first opposite bit.
- Pulse mode (mode_pulse=1): z is nonzero for exactly the one cycle following a hit, with polarity matching the run, then returns to 00 regardless of w_valid.
- Mode switching: mode_pulse changing mid-run takes effect on the next edge. Switching to level mode while saturated asserts z on that edge; switching to pulse mode while saturated gives z=00 unless a hit occurs on that edge.
- Event counters: on a hit, the counter for the run polarity increments in both modes. Each counter saturates at 2^EVT_W-1.
- clr_cnt: on an edge with clr_cnt=1, both counters become 0. If a hit occurs on the same edge, clr_cnt has priority and the result is 0.
- run_len is capped at RUN_LEN; no wrap-around.

Decomposition:
- Package run_det_pkg holds:
  - state enum: IDLE, ZRUN, ORUN;
  - z encodings: Z_NONE=2'b00, Z_ZERO=2'b01, Z_ONE=2'b10.
- Sub-module sat_counter holds the saturating EVT_W-bit counter with clear and inc inputs (clear has priority). It is instantiated twice, once per polarity.
- The FSM, run counter and output logic stay in run_len_detector.

Test Plan:
1. RUN_LEN=4, level mode. After reset, four accepted 0s -> z=01 and run_len=4 after the 4th edge, zero_evt_cnt=1. A 5th 0 -> z stays 01, run_len=4, count stays 1.
2. Accepted 0,0,0,1,1,1,1 -> z=00 through the 0s. After the 4th 1: z=10, one_evt_cnt=1, zero_evt_cnt=0. A following 0 -> z=00, run_len=1, cur_bit=0.
3. Pulse mode, six accepted 1s -> z=10 for exactly one cycle after the 4th sample, then 00. one_evt_cnt=1 and run_len stays 4.
4. w_valid gaps: pattern 0,idle,0,idle,idle,0,idle,0 -> run_len steps 1,2,3,4 on the valid edges only. z=01 appears only after the 4th valid sample.
5. rst asserted after three 0s -> next cycle all outputs are 0 and the state is IDLE. A single 0 then gives run_len=1, z=00.
6. EVT_W=2: five 0-runs of length 4, each separated by a 1 -> zero_evt_cnt saturates at 3. clr_cnt asserted on the same edge as a 1-run hit -> one_evt_cnt=0.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared types for the run-length detector: FSM state encoding and z output codes.
package run_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ZRUN = 2'b01,
        ORUN = 2'b10
    } state_t;

    localparam logic [1:0] Z_NONE = 2'b00;
    localparam logic [1:0] Z_ZERO = 2'b01;
    localparam logic [1:0] Z_ONE  = 2'b10;

    // Detection code reported for a run of the given polarity.
    function automatic logic [1:0] zCode(input state_t s);
        case (s)
            ZRUN:    zCode = Z_ZERO;
            ORUN:    zCode = Z_ONE;
            default: zCode = Z_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; clear wins over increment and the count sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/run_len_detector.sv
// Detects runs of RUN_LEN identical qualified bits on a serial stream, with level/pulse
// reporting and saturating per-polarity event counters. All outputs are registered.
module run_len_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = $clog2(RUN_LEN + 1),
    parameter int EVT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_valid,
    input  logic             w,
    input  logic             mode_pulse,
    input  logic             clr_cnt,
    output logic [1:0]       z,
    output logic [CNT_W-1:0] run_len,
    output logic             cur_bit,
    output logic [EVT_W-1:0] zero_evt_cnt,
    output logic [EVT_W-1:0] one_evt_cnt
);

    localparam logic [CNT_W-1:0] RunMax = CNT_W'(RUN_LEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] runLen_q, runLen_d;
    logic [1:0]       z_q, z_d;
    logic             hit;
    logic             runBit;
    logic             zeroInc, oneInc;

    assign runBit = (state_q == ORUN);

    // A hit is the single step from RUN_LEN-1 to RUN_LEN; once saturated the run just holds.
    always_comb begin
        state_d  = state_q;
        runLen_d = runLen_q;
        hit      = 1'b0;
        if (w_valid) begin
            if ((state_q == IDLE) || (w != runBit)) begin
                state_d  = w ? ORUN : ZRUN;
                runLen_d = CNT_W'(1);
            end else if (runLen_q != RunMax) begin
                runLen_d = runLen_q + CNT_W'(1);
                hit      = (runLen_q == (RunMax - CNT_W'(1)));
            end
        end

        if (mode_pulse) begin
            z_d = hit ? zCode(state_d) : Z_NONE;
        end else begin
            z_d = (runLen_d == RunMax) ? zCode(state_d) : Z_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            runLen_q <= '0;
            z_q      <= Z_NONE;
        end else begin
            state_q  <= state_d;
            runLen_q <= runLen_d;
            z_q      <= z_d;
        end
    end

    assign zeroInc = hit && (state_d == ZRUN);
    assign oneInc  = hit && (state_d == ORUN);

    sat_counter #(.W(EVT_W)) u_zero_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_cnt),
        .inc_i (zeroInc),
        .cnt_o (zero_evt_cnt)
    );

    sat_counter #(.W(EVT_W)) u_one_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_cnt),
        .inc_i (oneInc),
        .cnt_o (one_evt_cnt)
    );

    assign z       = z_q;
    assign run_len = runLen_q;
    assign cur_bit = (state_q == ORUN);

endmodule
